// File: rtl/lifo_rd_ctrl.sv
// LIFO pop controller: N-word command in, valid/ready word stream out; LIFO_RD_CTRL_ASSERT_EN adds sim checks.
// First pop one cycle after accept, data valid two cycles after pop; ready_i low stalls pops once two words are held.
module lifo_rd_ctrl #(
  parameter int DWIDTH = 8,
  parameter int AWIDTH = 4
) (
  input  logic              clk_i,
  input  logic              arst_i,
  input  logic              cmd_valid_i,
  output logic              cmd_ready_o,
  input  logic [AWIDTH:0]   cmd_len_i,
  output logic              lifo_rdreq_o,
  input  logic [DWIDTH-1:0] lifo_q_i,
  input  logic              lifo_empty_i,
  input  logic              lifo_wrreq_i,
  output logic [DWIDTH-1:0] data_o,
  output logic              last_o,
  output logic              valid_o,
  input  logic              ready_i
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_POP   = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;

  localparam logic [AWIDTH:0] ONE = {{AWIDTH{1'b0}}, 1'b1};

  logic [1:0]             state_q, state_d;
  logic [AWIDTH:0]        remaining_q, remaining_d;
  logic                   inflight_q;
  logic                   inflight_last_q;
  logic [1:0]             occ_q, occ_d;
  logic                   wr_ptr_q, rd_ptr_q;
  logic [1:0][DWIDTH-1:0] buf_dat_q;
  logic [1:0]             buf_last_q;

  logic       cmd_acc;
  logic       xfer;
  logic       pop;
  logic [2:0] fill_next;

  assign cmd_ready_o = (state_q == S_IDLE);
  assign cmd_acc     = cmd_valid_i && cmd_ready_o;
  assign valid_o     = (occ_q != 2'd0);
  assign xfer        = valid_o && ready_i;
  assign data_o      = buf_dat_q[rd_ptr_q];
  assign last_o      = valid_o && buf_last_q[rd_ptr_q];

  // Words the buffer will hold next cycle; a new pop is only safe if its data still fits after that.
  assign fill_next = {1'b0, occ_q} + {2'b00, inflight_q} - {2'b00, xfer};

  assign pop = (state_q == S_POP) && (remaining_q != '0) && !lifo_empty_i &&
               !lifo_wrreq_i && (fill_next < 3'd2);
  assign lifo_rdreq_o = pop;

  always_comb begin
    state_d     = state_q;
    remaining_d = remaining_q;
    case (state_q)
      S_IDLE: begin
        if (cmd_acc && (cmd_len_i != '0)) begin
          state_d     = S_POP;
          remaining_d = cmd_len_i;
        end
      end
      S_POP: begin
        if (pop) begin
          remaining_d = remaining_q - ONE;
          if (remaining_q == ONE) state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (xfer && last_o) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    occ_d = occ_q;
    case ({inflight_q, xfer})
      2'b10:   occ_d = occ_q + 2'd1;
      2'b01:   occ_d = occ_q - 2'd1;
      default: occ_d = occ_q;
    endcase
  end

  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      state_q         <= S_IDLE;
      remaining_q     <= '0;
      inflight_q      <= 1'b0;
      inflight_last_q <= 1'b0;
      occ_q           <= 2'd0;
      wr_ptr_q        <= 1'b0;
      rd_ptr_q        <= 1'b0;
      buf_dat_q       <= '0;
      buf_last_q      <= '0;
    end else begin
      state_q         <= state_d;
      remaining_q     <= remaining_d;
      inflight_q      <= pop;
      inflight_last_q <= pop && (remaining_q == ONE);
      occ_q           <= occ_d;
      if (inflight_q) begin
        buf_dat_q[wr_ptr_q]  <= lifo_q_i;
        buf_last_q[wr_ptr_q] <= inflight_last_q;
        wr_ptr_q             <= ~wr_ptr_q;
      end
      if (xfer) rd_ptr_q <= ~rd_ptr_q;
    end
  end

`ifdef LIFO_RD_CTRL_ASSERT_EN
  localparam logic [AWIDTH:0] MAX_LEN = {1'b1, {AWIDTH{1'b0}}};

  logic              hold_q;
  logic [DWIDTH-1:0] hold_dat_q;
  logic              hold_last_q;

  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      hold_q      <= 1'b0;
      hold_dat_q  <= '0;
      hold_last_q <= 1'b0;
    end else begin
      hold_q      <= valid_o && !ready_i;
      hold_dat_q  <= data_o;
      hold_last_q <= last_o;
    end
  end

  always @(posedge clk_i) begin
    if (!arst_i) begin
      assert (!(lifo_rdreq_o && (lifo_empty_i || lifo_wrreq_i)))
        else $error("lifo_rd_ctrl: pop issued while LIFO empty or being pushed");
      assert (!hold_q || ((data_o == hold_dat_q) && (last_o == hold_last_q)))
        else $error("lifo_rd_ctrl: output changed while stalled");
      assert (occ_q <= 2'd2)
        else $error("lifo_rd_ctrl: output buffer overflow");
      assert (!cmd_acc || (cmd_len_i <= MAX_LEN))
        else $error("lifo_rd_ctrl: command length exceeds LIFO depth");
    end
  end
`endif

endmodule

// File: tb/tb_lifo_rd_ctrl.sv
// Directed and randomized bench for lifo_rd_ctrl with a behavioural LIFO and a pop-order scoreboard.
module tb_lifo_rd_ctrl;
  localparam int DW = 8;
  localparam int AW = 4;

  logic          clk;
  logic          arst_i;
  logic          cmd_valid_i;
  logic          cmd_ready_o;
  logic [AW:0]   cmd_len_i;
  logic          lifo_rdreq_o;
  logic [DW-1:0] lifo_q_i;
  logic          lifo_empty_i;
  logic          lifo_wrreq_i;
  logic [DW-1:0] data_o;
  logic          last_o;
  logic          valid_o;
  logic          ready_i;

  int n_asrt = 0;
  int n_fail = 0;
  int cyc = 0;
  int acc_cyc = 0;
  int rdy_mode = 0;

  logic [DW-1:0] push_dat;
  logic [DW-1:0] stack[$];
  logic [DW-1:0] pre[$];
  logic [DW:0]   exp_q[$];
  int pops_total = 0;
  int xfers_total = 0;
  int cmd_len_m = 0;
  int cmd_pops = 0;

  logic [DW-1:0] out_log[$];
  logic          last_log[$];
  int            xcyc_log[$];
  bit            hold_v = 1'b0;
  logic [DW-1:0] hold_d;
  logic          hold_l;
  bit            last_prev = 1'b0;

  lifo_rd_ctrl #(.DWIDTH(DW), .AWIDTH(AW)) dut (
    .clk_i        (clk),
    .arst_i       (arst_i),
    .cmd_valid_i  (cmd_valid_i),
    .cmd_ready_o  (cmd_ready_o),
    .cmd_len_i    (cmd_len_i),
    .lifo_rdreq_o (lifo_rdreq_o),
    .lifo_q_i     (lifo_q_i),
    .lifo_empty_i (lifo_empty_i),
    .lifo_wrreq_i (lifo_wrreq_i),
    .data_o       (data_o),
    .last_o       (last_o),
    .valid_o      (valid_o),
    .ready_i      (ready_i)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: observed no end of test, expected completion");
    $fatal(1, "watchdog expired");
  end

  always @(posedge clk) cyc++;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asrt++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Behavioural LIFO with push priority; every real pop also queues the word the stream must show.
  always @(posedge clk or posedge arst_i) begin
    if (arst_i) begin
      exp_q.delete();
      pops_total  = 0;
      xfers_total = 0;
      cmd_len_m   = 0;
      cmd_pops    = 0;
      lifo_q_i     <= '0;
      lifo_empty_i <= (stack.size() == 0);
    end else begin
      logic [DW-1:0] w;
      if (valid_o && ready_i) xfers_total++;
      if (cmd_valid_i && cmd_ready_o && (cmd_len_i != '0)) begin
        cmd_len_m = int'(cmd_len_i);
        cmd_pops  = 0;
      end
      if (lifo_wrreq_i) begin
        if (lifo_rdreq_o && (stack.size() > 0)) lifo_q_i <= stack[$];
        stack.push_back(push_dat);
      end else if (lifo_rdreq_o && (stack.size() > 0)) begin
        w = stack.pop_back();
        lifo_q_i <= w;
        cmd_pops++;
        pops_total++;
        exp_q.push_back({(cmd_pops == cmd_len_m), w});
      end
      lifo_empty_i <= (stack.size() == 0);
    end
  end

  always @(negedge clk) begin
    if (arst_i) begin
      hold_v    = 1'b0;
      last_prev = 1'b0;
    end else begin
      logic [DW:0] e;
      if (hold_v) begin
        chk("hold_valid", 32'(valid_o), 32'd1);
        chk("hold_data", 32'(data_o), 32'(hold_d));
        chk("hold_last", 32'(last_o), 32'(hold_l));
      end
      if (last_prev) chk("turnaround_ready", 32'(cmd_ready_o), 32'd1);
      if (lifo_rdreq_o) chk("rdreq_legal", 32'({lifo_empty_i, lifo_wrreq_i}), 32'd0);
      if (pops_total != xfers_total)
        chk("occ_bound", 32'((pops_total - xfers_total) <= 2), 32'd1);
      hold_v    = valid_o && !ready_i;
      hold_d    = data_o;
      hold_l    = last_o;
      last_prev = 1'b0;
      if (valid_o && ready_i) begin
        out_log.push_back(data_o);
        last_log.push_back(last_o);
        xcyc_log.push_back(cyc);
        last_prev = last_o;
        if (exp_q.size() == 0) begin
          chk("spurious_word", 32'(exp_q.size()), 32'd1);
        end else begin
          e = exp_q.pop_front();
          chk("sb_data", 32'(data_o), 32'(e[DW-1:0]));
          chk("sb_last", 32'(last_o), 32'(e[DW]));
        end
      end
    end
  end

  initial begin
    int k = 0;
    forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
        0:       ready_i = 1'b1;
        1:       ready_i = ((k % 4) == 0) || ((k % 4) == 3);
        2:       ready_i = 1'($urandom_range(1));
        default: ready_i = 1'b0;
      endcase
      k++;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_logs();
    out_log.delete();
    last_log.delete();
    xcyc_log.delete();
  endtask

  task automatic preload_seq(input int n, input int base);
    stack.delete();
    for (int i = 0; i < n; i++) stack.push_back(8'(base + i));
    pre = stack;
    step();
  endtask

  task automatic preload_rand(input int n);
    stack.delete();
    for (int i = 0; i < n; i++) stack.push_back(8'($urandom));
    pre = stack;
    step();
  endtask

  task automatic send_cmd(input int len);
    int n = 0;
    cmd_valid_i = 1'b1;
    cmd_len_i   = (AW + 1)'(len);
    while (!cmd_ready_o && (n < 50)) begin
      step();
      n++;
    end
    step();
    acc_cyc     = cyc;
    cmd_valid_i = 1'b0;
    chk("cmd_accept_wait", 32'(n < 50), 32'd1);
  endtask

  task automatic wait_idle(input int budget, input bit rand_push);
    int n = 0;
    do begin
      if (rand_push && (stack.size() < 15) && ($urandom_range(3) == 0)) begin
        lifo_wrreq_i = 1'b1;
        push_dat     = 8'($urandom);
      end else begin
        lifo_wrreq_i = 1'b0;
      end
      step();
      n++;
    end while (!(cmd_ready_o && !valid_o && (exp_q.size() == 0)) && (n < budget));
    lifo_wrreq_i = 1'b0;
    chk("idle_timeout", 32'(n < budget), 32'd1);
  endtask

  initial begin
    int len;
    int npre;
    arst_i       = 1'b0;
    cmd_valid_i  = 1'b0;
    cmd_len_i    = '0;
    lifo_wrreq_i = 1'b0;
    push_dat     = '0;
    ready_i      = 1'b1;
    #1 arst_i = 1'b1;
    #1;
    chk("rst_cmd_ready", 32'(cmd_ready_o), 32'd1);
    chk("rst_rdreq", 32'(lifo_rdreq_o), 32'd0);
    chk("rst_valid", 32'(valid_o), 32'd0);
    chk("rst_last", 32'(last_o), 32'd0);
    chk("rst_data", 32'(data_o), 32'd0);
    repeat (2) @(posedge clk);
    #1 arst_i = 1'b0;
    step();

    // Basic pop of 1,2,3,4 with exact latency and turnaround.
    preload_seq(4, 1);
    clear_logs();
    send_cmd(4);
    wait_idle(40, 1'b0);
    chk("basic_count", 32'(out_log.size()), 32'd4);
    for (int i = 0; i < 4; i++) begin
      chk("basic_data", 32'(out_log[i]), 32'(4 - i));
      chk("basic_last", 32'(last_log[i]), 32'(i == 3));
      chk("basic_cycle", 32'(xcyc_log[i] - acc_cyc), 32'(2 + i));
    end
    chk("basic_turnaround", 32'(cyc - acc_cyc), 32'd6);

    // Backpressure with ready pattern 1,0,0,1.
    rdy_mode = 1;
    preload_rand(8);
    clear_logs();
    send_cmd(8);
    wait_idle(200, 1'b0);
    chk("bp_count", 32'(out_log.size()), 32'd8);
    for (int i = 0; i < 8; i++) chk("bp_data", 32'(out_log[i]), 32'(pre[7 - i]));
    rdy_mode = 0;
    step();

    // Pushes collide with the first pop opportunities.
    preload_seq(4, 8'h10);
    clear_logs();
    send_cmd(3);
    lifo_wrreq_i = 1'b1;
    push_dat     = 8'h55;
    #1 chk("coll_rdreq0", 32'(lifo_rdreq_o), 32'd0);
    step();
    push_dat = 8'h66;
    #1 chk("coll_rdreq1", 32'(lifo_rdreq_o), 32'd0);
    step();
    lifo_wrreq_i = 1'b0;
    wait_idle(40, 1'b0);
    chk("coll_count", 32'(out_log.size()), 32'd3);
    chk("coll_w0", 32'(out_log[0]), 32'h66);
    chk("coll_w1", 32'(out_log[1]), 32'h55);
    chk("coll_w2", 32'(out_log[2]), 32'h13);
    chk("coll_last", 32'(last_log[2]), 32'd1);
    chk("coll_stack", 32'(stack.size()), 32'd3);

    // Empty LIFO mid-command: stall, then resume on a push.
    preload_seq(2, 8'h21);
    clear_logs();
    send_cmd(3);
    repeat (10) step();
    chk("stall_count", 32'(out_log.size()), 32'd2);
    chk("stall_rdreq", 32'(lifo_rdreq_o), 32'd0);
    chk("stall_cmd_ready", 32'(cmd_ready_o), 32'd0);
    lifo_wrreq_i = 1'b1;
    push_dat     = 8'hAA;
    step();
    lifo_wrreq_i = 1'b0;
    #1 chk("stall_resume_rdreq", 32'(lifo_rdreq_o), 32'd1);
    wait_idle(40, 1'b0);
    chk("stall_total", 32'(out_log.size()), 32'd3);
    chk("stall_w0", 32'(out_log[0]), 32'h22);
    chk("stall_w1", 32'(out_log[1]), 32'h21);
    chk("stall_w2", 32'(out_log[2]), 32'hAA);
    chk("stall_w2_last", 32'(last_log[2]), 32'd1);

    // Zero-length command is a no-op.
    preload_seq(3, 8'h40);
    clear_logs();
    send_cmd(0);
    for (int i = 0; i < 5; i++) begin
      chk("zero_rdreq", 32'(lifo_rdreq_o), 32'd0);
      chk("zero_cmd_ready", 32'(cmd_ready_o), 32'd1);
      step();
    end
    chk("zero_count", 32'(out_log.size()), 32'd0);

    // Maximum-length command drains a full LIFO.
    preload_seq(16, 8'h80);
    clear_logs();
    send_cmd(16);
    wait_idle(80, 1'b0);
    chk("max_count", 32'(out_log.size()), 32'd16);
    for (int i = 0; i < 16; i++) chk("max_data", 32'(out_log[i]), 32'(8'h8F - i));
    chk("max_empty", 32'(lifo_empty_i), 32'd1);

    // Reset while the output buffer is full.
    rdy_mode = 3;
    step();
    preload_seq(8, 8'hC0);
    clear_logs();
    send_cmd(8);
    repeat (6) step();
    chk("rst_mid_occ", 32'(pops_total - xfers_total), 32'd2);
    chk("rst_mid_valid_pre", 32'(valid_o), 32'd1);
    arst_i = 1'b1;
    #1;
    chk("rst_mid_valid", 32'(valid_o), 32'd0);
    chk("rst_mid_rdreq", 32'(lifo_rdreq_o), 32'd0);
    chk("rst_mid_cmd_ready", 32'(cmd_ready_o), 32'd1);
    step();
    arst_i   = 1'b0;
    rdy_mode = 0;
    for (int i = 0; i < 6; i++) begin
      step();
      chk("post_rst_idle", 32'(valid_o), 32'd0);
    end
    chk("post_rst_count", 32'(out_log.size()), 32'd0);
    send_cmd(2);
    wait_idle(40, 1'b0);
    chk("post_rst_cmd", 32'(out_log.size()), 32'd2);
    chk("post_rst_w0", 32'(out_log[0]), 32'hC5);

    // Randomized commands with random ready and concurrent pushes.
    rdy_mode = 2;
    for (int it = 0; it < 8; it++) begin
      npre = $urandom_range(12, 1);
      len  = $urandom_range(npre, 0);
      preload_rand(npre);
      clear_logs();
      send_cmd(len);
      wait_idle(600, 1'b1);
      chk("rand_count", 32'(out_log.size()), 32'(len));
      chk("rand_sb_empty", 32'(exp_q.size()), 32'd0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
    $finish;
  end

endmodule
